// File: rtl/unpacker_pkg.sv
// unpacker_pkg: shared widths and helpers for the FIFO word unpacker and
// its matching packer stage.
//   IDATAW_DEF / ODATAW_DEF : default FIFO word and output beat widths
//   beats()                 : beats per word
//   width_ok()              : true when a word splits into whole beats
package unpacker_pkg;

   localparam int unsigned IDATAW_DEF = 512;
   localparam int unsigned ODATAW_DEF = 64;

   function automatic int unsigned beats(input int unsigned iw, input int unsigned ow);
      return iw / ow;
   endfunction

   function automatic bit width_ok(input int unsigned iw, input int unsigned ow);
      return (ow != 0) && ((iw % ow) == 0);
   endfunction

endpackage

// File: rtl/fifo_word_unpacker_beat_counter.sv
// beat_counter: modulo-RATIO beat index, shared by the unpacker and packer.
// Ports:
//   clk, rst : clock, synchronous active-low reset
//   inc      : advance one beat (wraps to 0 after RATIO-1)
//   clear    : force index to 0 (wins over inc)
//   cnt      : current beat index
//   wrap_c   : index is RATIO-1 (combinational)
module beat_counter #(
   parameter int unsigned RATIO = 8,
   parameter int unsigned CNTW  = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            inc,
   input  logic            clear,
   output logic [CNTW-1:0] cnt,
   output logic            wrap_c
);

   assign wrap_c = (cnt == CNTW'(RATIO - 1));

   // Beat index register
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= wrap_c ? '0 : cnt + CNTW'(1);
      end
   end

endmodule

// File: rtl/fifo_word_unpacker.sv
// fifo_word_unpacker: pops one IDATAW-bit word from a peek FIFO and streams
// it out as RATIO ODATAW-bit beats, least significant slice first.
// Optional macro UNPACKER_STALL_CNT_EN adds a saturating stall counter port.
// Ports:
//   clk, rst   : clock, synchronous active-low reset
//   fifo_odata : FIFO head word (valid while fifo_empty=0)
//   fifo_empty : FIFO empty flag
//   fifo_pop   : pop request (combinational)
//   o_data     : current beat; o_valid/o_ready handshake; o_last on final beat
//   stall_cnt  : cycles with o_valid && !o_ready (macro builds only)
module fifo_word_unpacker
   import unpacker_pkg::*;
#(
   parameter int unsigned IDATAW = IDATAW_DEF,
   parameter int unsigned ODATAW = ODATAW_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IDATAW-1:0] fifo_odata,
   input  logic              fifo_empty,
   output logic              fifo_pop,
   output logic [ODATAW-1:0] o_data,
   output logic              o_valid,
   input  logic              o_ready,
`ifdef UNPACKER_STALL_CNT_EN
   output logic [31:0]       stall_cnt,
`endif
   output logic              o_last
);

   localparam int unsigned RATIO = beats(IDATAW, ODATAW);
   localparam int unsigned CNTW  = (RATIO > 1) ? $clog2(RATIO) : 1;

   if (!width_ok(IDATAW, ODATAW)) begin : g_bad_width
      $error("fifo_word_unpacker: IDATAW must be a multiple of ODATAW");
   end

   logic [IDATAW-1:0] word_reg;
   logic [CNTW-1:0]   beat_cnt;
   logic              busy;
   logic              wrap_c;
   logic              acc_c;
   logic              load_c;

   assign acc_c  = busy && o_ready;
   // Reload as the last beat leaves so consecutive words run without a bubble
   assign load_c = !fifo_empty && (!busy || (acc_c && wrap_c));

   assign fifo_pop = load_c && rst;
   assign o_valid  = busy;
   assign o_last   = busy && wrap_c;
   assign o_data   = word_reg[32'(beat_cnt) * ODATAW +: ODATAW];

   beat_counter #(
      .RATIO (RATIO),
      .CNTW  (CNTW)
   ) u_beat_counter (
      .clk    (clk),
      .rst    (rst),
      .inc    (acc_c && !wrap_c),
      .clear  (load_c || (acc_c && wrap_c)),
      .cnt    (beat_cnt),
      .wrap_c (wrap_c)
   );

   // Held word and occupancy flag
   always_ff @(posedge clk) begin
      if (!rst) begin
         word_reg <= '0;
         busy     <= 1'b0;
      end else if (load_c) begin
         word_reg <= fifo_odata;
         busy     <= 1'b1;
      end else if (acc_c && wrap_c) begin
         busy     <= 1'b0;
      end
   end

`ifdef UNPACKER_STALL_CNT_EN
   // Saturating count of back-pressured cycles
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (busy && !o_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// tb_fifo_word_unpacker: scoreboard bench for a 512->64 unpacker and a
// RATIO=1 (64->64) instance, each fed by a behavioural peek FIFO.
module tb_fifo_word_unpacker;

   localparam int unsigned IW = 512;
   localparam int unsigned OW = 64;
   localparam int unsigned R  = IW / OW;

   typedef struct packed {
      logic [OW-1:0] data;
      logic          last;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [IW-1:0] fifo_odata;
   logic          fifo_empty, fifo_pop;
   logic [OW-1:0] o_data;
   logic          o_valid, o_ready, o_last;

   logic [63:0]   f1_odata;
   logic          f1_empty, f1_pop;
   logic [63:0]   o1_data;
   logic          o1_valid, o1_ready, o1_last;
`ifdef UNPACKER_STALL_CNT_EN
   logic [31:0]   stall_cnt, stall_cnt1;
`endif

   fifo_word_unpacker #(.IDATAW(IW), .ODATAW(OW)) dut (
      .clk(clk), .rst(rst), .fifo_odata(fifo_odata), .fifo_empty(fifo_empty),
      .fifo_pop(fifo_pop), .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready),
`ifdef UNPACKER_STALL_CNT_EN
      .stall_cnt(stall_cnt),
`endif
      .o_last(o_last)
   );

   fifo_word_unpacker #(.IDATAW(64), .ODATAW(64)) dut1 (
      .clk(clk), .rst(rst), .fifo_odata(f1_odata), .fifo_empty(f1_empty),
      .fifo_pop(f1_pop), .o_data(o1_data), .o_valid(o1_valid), .o_ready(o1_ready),
`ifdef UNPACKER_STALL_CNT_EN
      .stall_cnt(stall_cnt1),
`endif
      .o_last(o1_last)
   );

   logic [IW-1:0] fq[$];
   beat_t         exp_q[$];
   logic [63:0]   fq1[$];
   logic [63:0]   exp1_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int accs, pops, pops_on_last, first_acc, last_acc;
   int accs1, pops1;

   task automatic fifo_drive();
      fifo_empty = (fq.size() == 0);
      fifo_odata = fifo_empty ? '0 : fq[0];
      f1_empty   = (fq1.size() == 0);
      f1_odata   = f1_empty ? '0 : fq1[0];
   endtask

   task automatic push_word(input logic [IW-1:0] w);
      beat_t b;
      fq.push_back(w);
      for (int k = 0; k < R; k++) begin
         b.data = w[k*OW +: OW];
         b.last = (k == R - 1);
         exp_q.push_back(b);
      end
      fifo_drive();
   endtask

   task automatic push_word1(input logic [63:0] w);
      fq1.push_back(w);
      exp1_q.push_back(w);
      fifo_drive();
   endtask

   function automatic logic [IW-1:0] make_word(input logic [7:0] base);
      logic [IW-1:0] w;
      for (int k = 0; k < R; k++) w[k*OW +: OW] = {8{base + 8'(k)}};
      return w;
   endfunction

   // One clock: score accepts/pops seen before the edge, then advance the FIFOs
   task automatic tick();
      logic  p, p1, a, a1;
      beat_t e;
      logic [63:0] e1;
      #1;
      p  = fifo_pop;
      p1 = f1_pop;
      a  = (o_valid === 1'b1) && (o_ready === 1'b1);
      a1 = (o1_valid === 1'b1) && (o1_ready === 1'b1);
      if (a) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected got data=%h last=%b", o_data, o_last);
         end else begin
            e = exp_q.pop_front();
            if (o_data !== e.data || o_last !== e.last) begin
               errors++;
               $display("FAIL beat got data=%h last=%b exp data=%h last=%b",
                        o_data, o_last, e.data, e.last);
            end
         end
         if (accs == 0) first_acc = cyc;
         last_acc = cyc;
         accs++;
         if (p === 1'b1) pops_on_last++;
      end
      if (a1) begin
         checks++;
         if (exp1_q.size() == 0) begin
            errors++;
            $display("FAIL beat1_unexpected got data=%h", o1_data);
         end else begin
            e1 = exp1_q.pop_front();
            if (o1_data !== e1 || o1_last !== 1'b1) begin
               errors++;
               $display("FAIL beat1 got data=%h last=%b exp data=%h last=1", o1_data, o1_last, e1);
            end
         end
         accs1++;
      end
      if (p === 1'b1) pops++;
      if (p1 === 1'b1) pops1++;
      @(posedge clk);
      if (p === 1'b1 && fq.size() > 0) void'(fq.pop_front());
      if (p1 === 1'b1 && fq1.size() > 0) void'(fq1.pop_front());
      cyc++;
      @(negedge clk);
      fifo_drive();
   endtask

   task automatic test_reset();
      rst = 1'b0; o_ready = 1'b0; o1_ready = 1'b0;
      fifo_drive();
      push_word(make_word(8'h00));
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (fifo_pop !== 1'b0 || o_valid !== 1'b0 || o_data !== '0) begin
            errors++;
            $display("FAIL reset cycle %0d got pop=%b valid=%b data=%h exp 0 0 0",
                     i, fifo_pop, o_valid, o_data);
         end
      end
   endtask

   task automatic test_single_word();
      pops = 0; accs = 0;
      rst = 1'b1; o_ready = 1'b1;
      tick();
      checks++;
      if (pops !== 1 || o_valid !== 1'b1) begin
         errors++;
         $display("FAIL single_latency got pops=%0d valid=%b exp 1 1", pops, o_valid);
      end
      for (int i = 0; i < 12; i++) tick();
      checks++;
      if (accs !== 8 || (last_acc - first_acc) !== 7 || pops !== 1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL single_word got accs=%0d span=%0d pops=%0d left=%0d exp 8 7 1 0",
                  accs, last_acc - first_acc, pops, exp_q.size());
      end
      checks++;
      if (o_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_drain got valid=%b exp 0", o_valid);
      end
   endtask

   task automatic test_back_to_back();
      pops = 0; accs = 0; pops_on_last = 0;
      o_ready = 1'b1;
      push_word(make_word(8'h10));
      push_word(make_word(8'h20));
      for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick();
      checks++;
      if (accs !== 16 || (last_acc - first_acc) !== 15 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_stream got accs=%0d span=%0d left=%0d exp 16 15 0",
                  accs, last_acc - first_acc, exp_q.size());
      end
      checks++;
      if (pops !== 2 || pops_on_last !== 1) begin
         errors++;
         $display("FAIL b2b_pops got pops=%0d on_last=%0d exp 2 1", pops, pops_on_last);
      end
      tick();
      checks++;
      if (o_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drain got valid=%b exp 0", o_valid);
      end
   endtask

   task automatic test_backpressure();
      logic [IW-1:0] w;
      int stalls;
      w = make_word(8'h40);
      pops = 0; accs = 0; stalls = 0;
      push_word(w);
      for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
         o_ready = 1'b1;
         if (o_valid === 1'b1 && accs == 3 && stalls < 2) begin
            o_ready = 1'b0;
            checks++;
            if (o_data !== w[3*OW +: OW] || o_last !== 1'b0) begin
               errors++;
               $display("FAIL stall_hold %0d got data=%h last=%b exp data=%h last=0",
                        stalls, o_data, o_last, w[3*OW +: OW]);
            end
            stalls++;
         end
         tick();
      end
      checks++;
      if (accs !== 8 || pops !== 1 || stalls !== 2) begin
         errors++;
         $display("FAIL backpressure got accs=%0d pops=%0d stalls=%0d exp 8 1 2", accs, pops, stalls);
      end
`ifdef UNPACKER_STALL_CNT_EN
      checks++;
      if (stall_cnt !== 32'd2) begin
         errors++;
         $display("FAIL stall_cnt got %0d exp 2", stall_cnt);
      end
`endif
   endtask

   task automatic test_reset_mid();
      accs = 0; pops = 0;
      o_ready = 1'b1;
      push_word(make_word(8'h60));
      for (int i = 0; i < 30 && accs < 5; i++) tick();
      rst = 1'b0; o_ready = 1'b0;
      exp_q.delete();
      pops = 0;
      push_word(make_word(8'h80));
      tick();
      checks++;
      if (o_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_valid got %b exp 0", o_valid);
      end
      tick();
      checks++;
      if (pops !== 0 || fifo_pop !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_pop got pops=%0d pop=%b exp 0 0", pops, fifo_pop);
      end
      rst = 1'b1; o_ready = 1'b1; accs = 0;
      for (int i = 0; i < 30 && exp_q.size() > 0; i++) tick();
      checks++;
      if (accs !== 8 || pops !== 1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL reset_mid_resume got accs=%0d pops=%0d left=%0d exp 8 1 0",
                  accs, pops, exp_q.size());
      end
   endtask

   task automatic test_ratio1();
      logic [63:0] h1, h2;
      h1 = 64'hDEAD_BEEF_0123_4567;
      h2 = 64'hA5A5_5A5A_F00D_CAFE;
      pops1 = 0; accs1 = 0; o1_ready = 1'b0;
      push_word1(h1);
      push_word1(h2);
      tick();
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (o1_valid !== 1'b1 || o1_data !== h1 || o1_last !== 1'b1 || pops1 !== 1) begin
            errors++;
            $display("FAIL ratio1_hold %0d got valid=%b data=%h last=%b pops=%0d exp 1 %h 1 1",
                     i, o1_valid, o1_data, o1_last, pops1, h1);
         end
         tick();
      end
      o1_ready = 1'b1;
      for (int i = 0; i < 20 && exp1_q.size() > 0; i++) tick();
      checks++;
      if (accs1 !== 2 || pops1 !== 2 || exp1_q.size() != 0) begin
         errors++;
         $display("FAIL ratio1_drain got accs=%0d pops=%0d left=%0d exp 2 2 0",
                  accs1, pops1, exp1_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_ratio1();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
